// File: rtl/regfile_read_arbiter_if.sv
// Bundle of requester, consumer and grant signals shared by the read arbiter
// and whatever drives it; master drives requests/data/ack, slave arbitrates.
interface regfile_read_arbiter_if #(
  parameter int WIDTH = 16
);
  logic [3:0]       req;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic             ack;
  logic [3:0]       gnt;
  logic [1:0]       select;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;

  modport master (
    output req, d0, d1, d2, d3, ack,
    input  gnt, select, dout, dout_valid, busy
  );

  modport slave (
    input  req, d0, d1, d2, d3, ack,
    output gnt, select, dout, dout_valid, busy
  );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Four-way round-robin read arbiter with a per-owner beat quota and a single
// registered output beat that drains on ack independently of ownership.
module regfile_read_arbiter #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  regfile_read_arbiter_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       select_q, select_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [3:0]       hold_q, hold_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             busy_q, busy_d;
  logic             load_s;
  logic [1:0]       winner_s;
  logic [WIDTH-1:0] owner_data_s;

  // Scan last+1, last+2, ... modulo 4; the last candidate is the previous owner.
  function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] w;
    logic       found;
    w     = last + 2'd1;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return w;
  endfunction

  assign winner_s = pick_winner(bus.req, last_q);

  // Shared 4:1 read mux steered by the current owner.
  always_comb begin
    case (owner_q)
      2'd0:    owner_data_s = bus.d0;
      2'd1:    owner_data_s = bus.d1;
      2'd2:    owner_data_s = bus.d2;
      2'd3:    owner_data_s = bus.d3;
      default: owner_data_s = bus.d0;
    endcase
  end

  // Next-state, grant and beat-load decisions.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    select_d = select_q;
    gnt_d    = gnt_q;
    hold_d   = hold_q;
    dout_d   = dout_q;
    dv_d     = dv_q;
    load_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req != 4'b0000) begin
          state_d  = GRANT;
          owner_d  = winner_s;
          select_d = winner_s;
          gnt_d    = 4'b0001 << winner_s;
          hold_d   = 4'd0;
        end else begin
          gnt_d    = 4'b0000;
        end
      end
      GRANT: begin
        if (!bus.req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          last_d  = owner_q;
        end else if (hold_q == HOLD_MAX) begin
          // Quota spent: yield only if someone else is waiting, else renew.
          if ((bus.req & ~(4'b0001 << owner_q)) != 4'b0000) begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            last_d  = owner_q;
          end else begin
            hold_d  = 4'd0;
          end
        end else if (!dv_q || bus.ack) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase

    if (load_s) begin
      dout_d = owner_data_s;
      dv_d   = 1'b1;
      hold_d = hold_q + 4'd1;
    end else if (dv_q && bus.ack) begin
      dv_d   = 1'b0;
    end else begin
      dv_d   = dv_q;
    end
    busy_d = (state_d == GRANT);
  end

  // All arbiter state and outputs; reset leaves requester 0 next in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 2'd0;
      last_q   <= 2'd3;
      select_q <= 2'd0;
      gnt_q    <= 4'b0000;
      hold_q   <= 4'd0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      select_q <= select_d;
      gnt_q    <= gnt_d;
      hold_q   <= hold_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.select     = select_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench: fixed vector table, directed corner sequences and a
// randomized run against a behavioural arbitration model.
module tb_regfile_read_arbiter;
  localparam int WIDTH    = 16;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  regfile_read_arbiter_if #(.WIDTH(WIDTH)) bus ();

  regfile_read_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: who owns the grant, how many beats it has taken.
  bit          m_grant;
  int          m_owner;
  int          m_last;
  int          m_sel;
  int          m_hold;
  logic [15:0] m_dout;
  bit          m_dv;

  typedef struct {
    logic [3:0]  req;
    logic        ack;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        dv;
    logic [15:0] dout;
    logic        busy;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_grant = 0; m_owner = 0; m_last = 3; m_sel = 0; m_hold = 0; m_dout = 16'h0000; m_dv = 0;
  endtask

  task automatic model_step();
    logic [15:0] d [4];
    bit load;
    int others;
    d[0] = bus.d0; d[1] = bus.d1; d[2] = bus.d2; d[3] = bus.d3;
    load = 0;
    if (!m_grant) begin
      if (bus.req != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          int idx;
          idx = (m_last + k) % 4;
          if (!m_grant && bus.req[idx]) begin
            m_grant = 1; m_owner = idx; m_sel = idx; m_hold = 0;
          end
        end
      end
    end else begin
      others = 0;
      for (int i = 0; i < 4; i++) if (i != m_owner && bus.req[i]) others++;
      if (!bus.req[m_owner]) begin
        m_grant = 0; m_last = m_owner;
      end else if (m_hold == MAX_HOLD) begin
        if (others > 0) begin
          m_grant = 0; m_last = m_owner;
        end else begin
          m_hold = 0;
        end
      end else if (!m_dv || bus.ack) begin
        load = 1;
      end
    end
    if (load) begin
      m_dout = d[m_owner]; m_dv = 1; m_hold++;
    end else if (m_dv && bus.ack) begin
      m_dv = 0;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.req = 4'b0000; bus.ack = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg;
    eg = m_grant ? 4'(1 << m_owner) : 4'b0000;
    check({tag, ".gnt"},  {28'd0, bus.gnt}, {28'd0, eg});
    check({tag, ".sel"},  {30'd0, bus.select}, 32'(m_sel));
    check({tag, ".dv"},   {31'd0, bus.dout_valid}, {31'd0, m_dv});
    check({tag, ".dout"}, {16'd0, bus.dout}, {16'd0, m_dout});
    check({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, m_grant});
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b1;
    bus.req = 4'b0000; bus.ack = 1'b0;
    bus.d0 = 16'h1000; bus.d1 = 16'h1111; bus.d2 = 16'h2222; bus.d3 = 16'h3333;

    tbl[0]  = '{4'hF,    1'b1, 4'b0001, 2'd0, 1'b0, 16'h0000, 1'b1};
    tbl[1]  = '{4'hF,    1'b1, 4'b0001, 2'd0, 1'b1, 16'h1000, 1'b1};
    tbl[2]  = '{4'hF,    1'b1, 4'b0001, 2'd0, 1'b1, 16'h1000, 1'b1};
    tbl[3]  = '{4'hF,    1'b1, 4'b0001, 2'd0, 1'b1, 16'h1000, 1'b1};
    tbl[4]  = '{4'hF,    1'b1, 4'b0001, 2'd0, 1'b1, 16'h1000, 1'b1};
    tbl[5]  = '{4'hF,    1'b1, 4'b0000, 2'd0, 1'b0, 16'h1000, 1'b0};
    tbl[6]  = '{4'hF,    1'b1, 4'b0010, 2'd1, 1'b0, 16'h1000, 1'b1};
    tbl[7]  = '{4'hF,    1'b0, 4'b0010, 2'd1, 1'b1, 16'h1111, 1'b1};
    tbl[8]  = '{4'hF,    1'b0, 4'b0010, 2'd1, 1'b1, 16'h1111, 1'b1};
    tbl[9]  = '{4'h0,    1'b0, 4'b0000, 2'd1, 1'b1, 16'h1111, 1'b0};
    tbl[10] = '{4'h0,    1'b1, 4'b0000, 2'd1, 1'b0, 16'h1111, 1'b0};
    tbl[11] = '{4'b1001, 1'b1, 4'b1000, 2'd3, 1'b0, 16'h1111, 1'b1};
    tbl[12] = '{4'b0001, 1'b1, 4'b0000, 2'd3, 1'b0, 16'h1111, 1'b0};
    tbl[13] = '{4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, 16'h1111, 1'b1};

    // Reset state
    do_reset();
    check("rst.gnt",  {28'd0, bus.gnt}, 32'h0);
    check("rst.sel",  {30'd0, bus.select}, 32'h0);
    check("rst.dv",   {31'd0, bus.dout_valid}, 32'h0);
    check("rst.dout", {16'd0, bus.dout}, 32'h0);
    check("rst.busy", {31'd0, bus.busy}, 32'h0);

    // Table: round-robin, quota release, back-pressure, voluntary release
    for (int i = 0; i < 14; i++) begin
      bus.req = tbl[i].req; bus.ack = tbl[i].ack;
      cycle();
      check($sformatf("tbl%0d.gnt", i),  {28'd0, bus.gnt}, {28'd0, tbl[i].gnt});
      check($sformatf("tbl%0d.sel", i),  {30'd0, bus.select}, {30'd0, tbl[i].sel});
      check($sformatf("tbl%0d.dv", i),   {31'd0, bus.dout_valid}, {31'd0, tbl[i].dv});
      check($sformatf("tbl%0d.dout", i), {16'd0, bus.dout}, {16'd0, tbl[i].dout});
      check($sformatf("tbl%0d.busy", i), {31'd0, bus.busy}, {31'd0, tbl[i].busy});
    end

    // Quota renewal for a lone requester, then forced release to requester 3
    do_reset();
    bus.d1 = 16'hA5A5; bus.req = 4'b0010; bus.ack = 1'b1;
    cycle();
    check("renew.gnt0", {28'd0, bus.gnt}, 32'h2);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check($sformatf("renew.beat%0d.dv", i), {31'd0, bus.dout_valid}, 32'h1);
      check($sformatf("renew.beat%0d.dout", i), {16'd0, bus.dout}, 32'hA5A5);
    end
    cycle();
    check("renew.gap.dv",  {31'd0, bus.dout_valid}, 32'h0);
    check("renew.gap.gnt", {28'd0, bus.gnt}, 32'h2);
    cycle();
    check("renew.resume.dv",  {31'd0, bus.dout_valid}, 32'h1);
    check("renew.resume.gnt", {28'd0, bus.gnt}, 32'h2);
    bus.req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("force.keep%0d.gnt", i), {28'd0, bus.gnt}, 32'h2);
    end
    cycle();
    check("force.gap.gnt", {28'd0, bus.gnt}, 32'h0);
    cycle();
    check("force.new.gnt", {28'd0, bus.gnt}, 32'h8);
    check("force.new.sel", {30'd0, bus.select}, 32'h3);

    // Back-pressure freezes the beat; ack resumes loading
    do_reset();
    bus.d2 = 16'h1234; bus.req = 4'b0100; bus.ack = 1'b0;
    cycle();
    check("bp.gnt", {28'd0, bus.gnt}, 32'h4);
    cycle();
    check("bp.load.dout", {16'd0, bus.dout}, 32'h1234);
    bus.d2 = 16'h5678;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check($sformatf("bp.hold%0d.dout", i), {16'd0, bus.dout}, 32'h1234);
      check($sformatf("bp.hold%0d.dv", i), {31'd0, bus.dout_valid}, 32'h1);
    end
    bus.ack = 1'b1;
    cycle();
    check("bp.resume.dout", {16'd0, bus.dout}, 32'h5678);
    check("bp.resume.dv", {31'd0, bus.dout_valid}, 32'h1);

    // Asynchronous reset mid-beat, then requester 0 wins first
    do_reset();
    bus.d0 = 16'hBEEF; bus.req = 4'b0001; bus.ack = 1'b0;
    cycle();
    cycle();
    check("ar.pre.dv", {31'd0, bus.dout_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("ar.gnt",  {28'd0, bus.gnt}, 32'h0);
    check("ar.dv",   {31'd0, bus.dout_valid}, 32'h0);
    check("ar.dout", {16'd0, bus.dout}, 32'h0);
    check("ar.busy", {31'd0, bus.busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    bus.req = 4'b1001; bus.ack = 1'b1;
    cycle();
    check("ar.first.gnt", {28'd0, bus.gnt}, 32'h1);
    check("ar.first.sel", {30'd0, bus.select}, 32'h0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
      bus.ack = ($urandom_range(0, 3) != 0);
      bus.d0 = 16'($urandom); bus.d1 = 16'($urandom);
      bus.d2 = 16'($urandom); bus.d3 = 16'($urandom);
      cycle();
      check_model($sformatf("rnd%0d", i));
      check($sformatf("rnd%0d.onehot", i), 32'($countones(bus.gnt) <= 1), 32'h1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
